// File: rtl/dps_sci_pkg.sv
// Shared definitions for the SCI receive path: state encodings, data width and default oversampling.
// Build option: DPS_SCI_RX_PARITY_EN adds the PARITY state encoding.
package dps_sci_pkg;

    localparam int DATA_W         = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef DPS_SCI_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } rx_state_e;

endpackage

// File: rtl/dps_sci_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RXD line; resets to the idle (high) level.
module dps_sci_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iASYNC,
    output logic oSYNC
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iASYNC};
        end
    end

    assign oSYNC = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dps_sci_rx_framer.sv
// Oversampling UART receive framer with a one-deep held output byte and valid/busy handoff.
// Build option: DPS_SCI_RX_PARITY_EN adds an even-parity bit between data and stop.
//
// Handshake: oRX_VALID/oRX_DATA hold a byte; it is consumed on any cycle with oRX_VALID=1 and
// iRX_BUSY=0. A new good frame may load in that same cycle; otherwise it is dropped (oOVERRUN).
module dps_sci_rx_framer
    import dps_sci_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iRX_EN,
    input  logic              iSAMPLE_TICK,
    input  logic              iUART_RXD,
    output logic              oRX_VALID,
    input  logic              iRX_BUSY,
    output logic [DATA_W-1:0] oRX_DATA,
    output logic              oFRAME_ERR,
    output logic              oOVERRUN,
    output logic              oPARITY_ERR,
    output logic [2:0]        oDBG_STATE
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic              rxd_s;
    rx_state_e         state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              good_frame;
    logic              frame_err_q, frame_err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic              accept;
    logic              sample_pt;
`ifdef DPS_SCI_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    dps_sci_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iASYNC  (iUART_RXD),
        .oSYNC   (rxd_s)
    );

    assign sample_pt = (tick_q == FULL_M1);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        good_frame  = 1'b0;
        frame_err_d = 1'b0;
`ifdef DPS_SCI_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (!iRX_EN) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else if (iSAMPLE_TICK) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? ST_IDLE : ST_DATA;
`ifdef DPS_SCI_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (sample_pt) begin
                        tick_d  = '0;
                        shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                        if (bit_q == LAST_BIT) begin
`ifdef DPS_SCI_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef DPS_SCI_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_pt) begin
                        tick_d       = '0;
                        par_bad_d    = ^{shift_q, rxd_s};
                        parity_err_d = ^{shift_q, rxd_s};
                        state_d      = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_pt) begin
                        tick_d = '0;
                        if (rxd_s) begin
                            state_d = ST_IDLE;
`ifdef DPS_SCI_RX_PARITY_EN
                            good_frame = !par_bad_q;
`else
                            good_frame = 1'b1;
`endif
                        end else begin
                            state_d     = ST_RECOVER;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                // A held-low line (break) parks here so it cannot be reframed repeatedly.
                ST_RECOVER: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        accept    = valid_q && !iRX_BUSY;
        valid_d   = valid_q && iRX_BUSY;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (good_frame) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef DPS_SCI_RX_PARITY_EN
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign oPARITY_ERR = parity_err_q;
`else
    assign oPARITY_ERR = 1'b0;
`endif

    assign oRX_VALID  = valid_q;
    assign oRX_DATA   = data_q;
    assign oFRAME_ERR = frame_err_q;
    assign oOVERRUN   = overrun_q;
    assign oDBG_STATE = state_q;

endmodule

// File: doc/dps_sci_rx_framer.md
DPS_SCI_RX_FRAMER -- requirements
Module: dps_sci_rx_framer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving sample ticks per bit period (legal values 8 or 16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the RXD synchronizer depth (minimum 2).
REQ-003 iCLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-004 inRESET  input  1  synchronous, active-low reset.
REQ-005 iRX_EN  input  1  receiver enable.
REQ-006 iSAMPLE_TICK  input  1  one-cycle strobe at OVERSAMPLE x baud rate.
REQ-007 iUART_RXD  input  1  asynchronous serial line; idle is high.
REQ-008 oRX_VALID  output  1  received byte is held and valid.
REQ-009 iRX_BUSY  input  1  downstream RX FIFO cannot accept the byte.
REQ-010 oRX_DATA  output  8  received byte.
REQ-011 oFRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-012 oOVERRUN  output  1  one-cycle pulse when a completed byte is dropped.
REQ-013 oPARITY_ERR  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-014 iUART_RXD SHALL pass through a SYNC_STAGES flop synchronizer; all frame logic SHALL use only the synchronized value.
REQ-015 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP and RECOVER; the tick counter and bit counter SHALL advance only on cycles where iSAMPLE_TICK=1.
REQ-016 IDLE->START SHALL occur on the first tick that sees the synchronized line low while iRX_EN=1; the tick counter SHALL clear at that point.
REQ-017 In START, at tick count OVERSAMPLE/2-1: if the line is still low, go to DATA; if high, return to IDLE (glitch) with no output.
REQ-018 DATA SHALL sample 8 bits, LSB first, each exactly OVERSAMPLE ticks after the previous sample point.
REQ-019 After the 8th bit: go to PARITY if parity is compiled in, otherwise go to STOP.
REQ-020 STOP SHALL sample once. If the sample is high the frame is good and the state returns to IDLE. If the sample is low, oFRAME_ERR SHALL pulse, the byte SHALL be discarded, and the state SHALL go to RECOVER.
REQ-021 RECOVER SHALL go to IDLE on the first tick that sees the line high, so a break condition does not produce repeated frames.
REQ-022 On a good frame, if the output is empty or being accepted in that same cycle (oRX_VALID=1 and iRX_BUSY=0), the new byte SHALL load into oRX_DATA and oRX_VALID SHALL be 1 on the next cycle.
REQ-023 oRX_VALID SHALL stay 1 and oRX_DATA SHALL stay stable until a cycle with iRX_BUSY=0; oRX_VALID SHALL clear after that cycle unless a new byte loads in it.
REQ-024 If a good frame completes while oRX_VALID=1 and iRX_BUSY=1, the new byte SHALL be dropped, the held byte SHALL be kept, and oOVERRUN SHALL pulse for one cycle.
REQ-025 When a frame has an error (framing or parity), only the error pulse SHALL fire; oOVERRUN SHALL never pulse for that frame.
REQ-026 iRX_EN=0 SHALL force the state to IDLE on the next cycle and discard any partial frame; the held output byte and oRX_VALID SHALL be unaffected.
REQ-027 iSAMPLE_TICK=0 SHALL freeze all counters and the state, except for REQ-026 and the output handshake.

Reset
REQ-028 With inRESET=0 at a clock edge: state=IDLE, counters=0, synchronizer flops=1, oRX_VALID=0, oRX_DATA=8'h00, oFRAME_ERR=0, oOVERRUN=0, oPARITY_ERR=0.
REQ-029 A reset during any frame SHALL abandon it; the first frame received after reset SHALL be received correctly.

Configuration
REQ-030 The macro DPS_SCI_RX_PARITY_EN, when defined, SHALL add the PARITY state, which samples one even-parity bit.
REQ-031 With DPS_SCI_RX_PARITY_EN defined, a parity mismatch SHALL pulse oPARITY_ERR, discard the byte, and continue to STOP.
REQ-032 With DPS_SCI_RX_PARITY_EN undefined, there SHALL be no PARITY state, the frame SHALL be 10 bits, and oPARITY_ERR SHALL be constant 0.

Structure
REQ-033 The shared package dps_sci_pkg SHALL hold the state encodings, the default OVERSAMPLE value, and the data width constant (8).
REQ-034 The synchronizer SHALL be the sub-module dps_sci_rx_sync, parameterized by SYNC_STAGES with reset value 1.

Verification (OVERSAMPLE=16, tick every 4 cycles)
REQ-035 Frame for 8'hA5 with iRX_BUSY=0 -> oRX_VALID=1 for one cycle, oRX_DATA=8'hA5, no error pulses.
REQ-036 Low glitch of 4 ticks on an idle line -> state returns to IDLE, oRX_VALID stays 0.
REQ-037 Frame for 8'h3C with the stop bit driven low, then the line held low for 40 ticks, then released -> exactly one oFRAME_ERR pulse, no valid output; a following 8'h55 frame is received correctly.
REQ-038 iRX_BUSY=1 while 8'h11 then 8'h22 are received -> oRX_DATA holds 8'h11, one oOVERRUN pulse; after iRX_BUSY is released, 8'h11 is accepted once.
REQ-039 inRESET=0 during bit 4 of a frame, released before the next frame -> all outputs 0 during reset; the next frame, 8'hF0, is received correctly.
REQ-040 With DPS_SCI_RX_PARITY_EN defined, 8'h07 sent with parity bit 0 -> one oPARITY_ERR pulse, no valid output; the same byte with parity bit 1 -> oRX_DATA=8'h07.
